gpmc_mailbox_reader: RTL and testbench
======================================

GPMC_MAILBOX_READER -- requirements
Module: gpmc_mailbox_reader

Interface
REQ-001 Parameter RING_LOG2, default 10: ring occupies BRAM words 0..2^RING_LOG2-1; pointers are RING_LOG2 bits.
REQ-002 Parameter WPTR_ADDR, default 11'h7FE: BRAM word holding the host write pointer.
REQ-003 Parameter RPTR_ADDR, default 11'h7FF: BRAM word holding the engine read pointer.
REQ-004 Parameter POLL_CYCLES, default 16: idle cycles between write-pointer polls when the ring is empty.
REQ-005 SYS_CLK  in  1  single clock; BRAM port B and all logic run on it.
REQ-006 SYS_RST_N  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  1 = engine runs; 0 = engine parks after finishing the current word.
REQ-008 b_ena  out  1  BRAM port-B enable.
REQ-009 b_wr  out  1  BRAM port-B write strobe.
REQ-010 b_addr  out  11  BRAM port-B word address.
REQ-011 b_din  out  16  BRAM port-B write data.
REQ-012 b_dout  in  16  BRAM port-B read data, valid one cycle after the read is issued.
REQ-013 m_valid  out  1  output word valid.
REQ-014 m_data  out  16  output word.
REQ-015 m_ready  in  1  downstream accepts m_data.
REQ-016 ring_empty  out  1  registered: 1 when cached wptr equals rptr.

Function
REQ-017 States: INIT, IDLE, RD_WPTR, CAP_WPTR, RD_DATA, CAP_DATA, OUT, WR_RPTR.
REQ-018 INIT: b_ena=1, b_wr=1, b_addr=RPTR_ADDR, b_din=0 for one cycle; then IDLE with poll counter=0.
REQ-019 IDLE: counter increments while enable=1; at POLL_CYCLES-1, go to RD_WPTR. With enable=0, hold and clear counter.
REQ-020 RD_WPTR: b_ena=1, b_wr=0, b_addr=WPTR_ADDR; next state CAP_WPTR.
REQ-021 CAP_WPTR: wptr_q <= b_dout[RING_LOG2-1:0]; upper bits ignored. If the new value != rptr, go to RD_DATA; else go to IDLE.
REQ-022 RD_DATA: b_ena=1, b_wr=0, b_addr=zero-extended rptr; next state CAP_DATA.
REQ-023 CAP_DATA: m_data <= b_dout; m_valid <= 1; next state OUT.
REQ-024 OUT: m_valid and m_data are held stable until m_ready=1. On handshake, m_valid <= 0, rptr <= rptr+1 mod 2^RING_LOG2, and the next state is WR_RPTR.
REQ-025 WR_RPTR: b_ena=1, b_wr=1, b_addr=RPTR_ADDR, b_din=zero-extended updated rptr.
REQ-026 Transition from WR_RPTR:
- enable=0: go to IDLE.
- rptr != wptr_q: go to RD_DATA.
- otherwise: go to RD_WPTR (immediate repoll, no wait).
REQ-027 Minimum per-word cost is 4 cycles (RD_DATA, CAP_DATA, OUT with m_ready=1, WR_RPTR).
REQ-028 Wrap: rptr at 2^RING_LOG2-1 advances to 0; no special-case cycle.
REQ-029 enable deasserted in any non-IDLE state:
- current word completes through WR_RPTR;
- a pending poll (RD_WPTR/CAP_WPTR) completes and returns to IDLE;
- m_valid is never withdrawn before handshake.
REQ-030 b_ena=0 and b_wr=0 in IDLE, CAP_WPTR, CAP_DATA and OUT.
REQ-031 Ring overflow (host wptr lapping rptr) is host responsibility and is not detected.

Reset
REQ-032 On SYS_RST_N low, asynchronously:
- state=INIT; rptr=0, wptr_q=0, poll counter=0;
- m_valid=0, m_data=0;
- b_ena=0, b_wr=0, b_addr=0, b_din=0;
- ring_empty=1.
REQ-033 Reset mid-word discards that word; after release, INIT rewrites RPTR_ADDR with 0.

Structure
REQ-034 Shared package gpmc_mbox_pkg holds the state enumeration and the default WPTR_ADDR/RPTR_ADDR constants, for reuse by the host driver bench.
REQ-035 One sub-module, gpmc_mbox_poll_timer: the POLL_CYCLES counter, with clear, run and expire signals.
REQ-036 All outputs are registered; no combinational path from m_ready or b_dout to any output.

Verification
REQ-037 Reset release, empty ring (wptr word=0):
- one INIT write of 0 to 11'h7FF;
- WPTR_ADDR reads spaced POLL_CYCLES+2 cycles apart;
- m_valid stays 0.
REQ-038 Three words: host writes 16'hA001/A002/A003 to words 0..2 and wptr=3, m_ready=1:
- m_data emits A001, A002, A003 in order, 4 cycles apart;
- 11'h7FF is written with 1, 2 and 3;
- ring_empty=1 afterwards.
REQ-039 Backpressure: one word 16'hBEEF, m_ready=0 for 10 cycles:
- m_valid=1 and m_data=BEEF held all 10 cycles;
- no BRAM access occurs until the cycle after m_ready=1.
REQ-040 Wrap: rptr=1022 and wptr=2 → words 1022, 1023, 0, 1 are emitted; the final rptr written is 2.
REQ-041 enable dropped while in OUT with 5 words pending:
- the current word completes and its RPTR write occurs;
- the engine then parks in IDLE;
- re-asserting enable resumes at the next word, with no loss or duplication.
REQ-042 SYS_RST_N pulsed low while in OUT:
- m_valid drops immediately;
- after release, RPTR is rewritten with 0 and the ring is re-read from word 0.

Source files
------------

// File: rtl/gpmc_mbox_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpmc_mbox_pkg
//  Purpose  : Definitions shared by the mailbox reader RTL and the host
//             driver bench: FSM state enumeration and the default BRAM
//             addresses of the host write pointer and engine read pointer.
//  Revision : 1.0  initial release
// ============================================================================
package gpmc_mbox_pkg;

   localparam int          c_ADDR_W            = 11;
   localparam int          c_DATA_W            = 16;
   localparam logic [10:0] c_WPTR_ADDR_DEFAULT = 11'h7FE;
   localparam logic [10:0] c_RPTR_ADDR_DEFAULT = 11'h7FF;

   typedef enum logic [2:0] {
      ST_INIT     = 3'd0,
      ST_IDLE     = 3'd1,
      ST_RD_WPTR  = 3'd2,
      ST_CAP_WPTR = 3'd3,
      ST_RD_DATA  = 3'd4,
      ST_CAP_DATA = 3'd5,
      ST_OUT      = 3'd6,
      ST_WR_RPTR  = 3'd7
   } mbox_state_t;

endpackage : gpmc_mbox_pkg
`default_nettype wire

// File: rtl/gpmc_mbox_poll_timer.sv
`default_nettype none
// ============================================================================
//  Module   : gpmc_mbox_poll_timer
//  Purpose  : Idle-interval counter between write-pointer polls. Counts
//             0..POLL_CYCLES-1 while i_run is high and wraps to 0 on expiry.
//  Ports    : SYS_CLK   in  clock
//             SYS_RST_N in  asynchronous active-low reset
//             i_clear   in  force counter to 0 (has priority over i_run)
//             i_run     in  advance the counter this cycle
//             o_expire  out high in the last counting cycle while running
//  Revision : 1.0  initial release
// ============================================================================
module gpmc_mbox_poll_timer #(
   parameter int POLL_CYCLES = 16
) (
   input  logic SYS_CLK,
   input  logic SYS_RST_N,
   input  logic i_clear,
   input  logic i_run,
   output logic o_expire
);

   localparam int                 c_CNT_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(POLL_CYCLES - 1);

   logic [c_CNT_W-1:0] r_count;
   logic               w_at_last;

   assign w_at_last = (r_count == c_LAST);
   assign o_expire  = i_run && w_at_last;

   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_run) begin
         r_count <= w_at_last ? '0 : r_count + c_CNT_W'(1);
      end
   end

endmodule : gpmc_mbox_poll_timer
`default_nettype wire

// File: rtl/gpmc_mailbox_reader.sv
`default_nettype none
// ============================================================================
//  Module   : gpmc_mailbox_reader
//  Purpose  : Drains a host-filled ring buffer held in a dual-port BRAM
//             (this block owns port B). Polls the host write pointer while
//             the ring is empty, streams each ring word out on a valid/ready
//             port and publishes the updated read pointer back to BRAM.
//  Ports    : SYS_CLK    in   clock (BRAM port B shares it)
//             SYS_RST_N  in   asynchronous active-low reset
//             enable     in   1 = run, 0 = park after the current word/poll
//             b_ena      out  BRAM port-B enable
//             b_wr       out  BRAM port-B write strobe
//             b_addr     out  BRAM port-B word address
//             b_din      out  BRAM port-B write data
//             b_dout     in   BRAM port-B read data (one cycle latency)
//             m_valid    out  output word valid
//             m_data     out  output word
//             m_ready    in   downstream accepts m_data
//             ring_empty out  cached write pointer equals read pointer
//  Revision : 1.0  initial release
// ============================================================================
module gpmc_mailbox_reader
   import gpmc_mbox_pkg::*;
#(
   parameter int          RING_LOG2   = 10,
   parameter logic [10:0] WPTR_ADDR   = c_WPTR_ADDR_DEFAULT,
   parameter logic [10:0] RPTR_ADDR   = c_RPTR_ADDR_DEFAULT,
   parameter int          POLL_CYCLES = 16
) (
   input  logic        SYS_CLK,
   input  logic        SYS_RST_N,
   input  logic        enable,
   output logic        b_ena,
   output logic        b_wr,
   output logic [10:0] b_addr,
   output logic [15:0] b_din,
   input  logic [15:0] b_dout,
   output logic        m_valid,
   output logic [15:0] m_data,
   input  logic        m_ready,
   output logic        ring_empty
);

   mbox_state_t          r_state;
   mbox_state_t          w_state_nxt;
   logic                 r_init_issued;
   logic [RING_LOG2-1:0] r_rptr;
   logic [RING_LOG2-1:0] w_rptr_nxt;
   logic [RING_LOG2-1:0] r_wptr_q;
   logic [RING_LOG2-1:0] w_wptr_nxt;
   logic [RING_LOG2-1:0] w_new_wptr;
   logic                 w_handshake;

   logic                 w_timer_clear;
   logic                 w_timer_run;
   logic                 w_timer_expire;

   logic                 w_b_ena;
   logic                 w_b_wr;
   logic [10:0]          w_b_addr;
   logic [15:0]          w_b_din;

   logic                 r_b_ena;
   logic                 r_b_wr;
   logic [10:0]          r_b_addr;
   logic [15:0]          r_b_din;
   logic                 r_m_valid;
   logic [15:0]          r_m_data;
   logic                 r_ring_empty;

   // Upper bits of the host pointer word are don't-care.
   assign w_new_wptr  = b_dout[RING_LOG2-1:0];
   assign w_handshake = (r_state == ST_OUT) && m_ready;

   // ------------------------------------------------------------------
   // Poll interval timer: runs only while idling with the engine enabled,
   // so every IDLE visit starts counting from zero.
   // ------------------------------------------------------------------
   assign w_timer_run   = (r_state == ST_IDLE) && enable;
   assign w_timer_clear = !w_timer_run;

   gpmc_mbox_poll_timer #(
      .POLL_CYCLES (POLL_CYCLES)
   ) u_poll_timer (
      .SYS_CLK   (SYS_CLK),
      .SYS_RST_N (SYS_RST_N),
      .i_clear   (w_timer_clear),
      .i_run     (w_timer_run),
      .o_expire  (w_timer_expire)
   );

   // ------------------------------------------------------------------
   // FSM: state register
   // INIT is held for two cycles: the first loads the port-B registers
   // with the RPTR clear write, the second presents it to the BRAM.
   // ------------------------------------------------------------------
   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         r_state       <= ST_INIT;
         r_init_issued <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_init_issued <= (r_state == ST_INIT) && !r_init_issued;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT:     if (r_init_issued) w_state_nxt = ST_IDLE;
         ST_IDLE:     if (w_timer_expire) w_state_nxt = ST_RD_WPTR;
         ST_RD_WPTR:  w_state_nxt = ST_CAP_WPTR;
         ST_CAP_WPTR: w_state_nxt = (enable && (w_new_wptr != r_rptr)) ? ST_RD_DATA : ST_IDLE;
         ST_RD_DATA:  w_state_nxt = ST_CAP_DATA;
         ST_CAP_DATA: w_state_nxt = ST_OUT;
         ST_OUT:      if (m_ready) w_state_nxt = ST_WR_RPTR;
         ST_WR_RPTR: begin
            if (!enable)                 w_state_nxt = ST_IDLE;
            else if (r_rptr != r_wptr_q) w_state_nxt = ST_RD_DATA;
            else                         w_state_nxt = ST_RD_WPTR;
         end
         default:     w_state_nxt = ST_INIT;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output decode. Decoded from the next state (and next pointer)
   // and then registered, so the registered port-B signals line up with
   // the state they belong to and reads land in the CAP_* states.
   // ------------------------------------------------------------------
   always_comb begin
      w_b_ena  = 1'b0;
      w_b_wr   = 1'b0;
      w_b_addr = '0;
      w_b_din  = '0;
      case (w_state_nxt)
         ST_INIT: begin
            w_b_ena  = 1'b1;
            w_b_wr   = 1'b1;
            w_b_addr = RPTR_ADDR;
         end
         ST_RD_WPTR: begin
            w_b_ena  = 1'b1;
            w_b_addr = WPTR_ADDR;
         end
         ST_RD_DATA: begin
            w_b_ena  = 1'b1;
            w_b_addr = 11'(w_rptr_nxt);
         end
         ST_WR_RPTR: begin
            w_b_ena  = 1'b1;
            w_b_wr   = 1'b1;
            w_b_addr = RPTR_ADDR;
            w_b_din  = 16'(w_rptr_nxt);
         end
         default: begin
            w_b_ena  = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Pointer next values
   // ------------------------------------------------------------------
   always_comb begin
      w_rptr_nxt = r_rptr;
      if (w_handshake) w_rptr_nxt = r_rptr + RING_LOG2'(1);   // natural wrap
      w_wptr_nxt = r_wptr_q;
      if (r_state == ST_CAP_WPTR) w_wptr_nxt = w_new_wptr;
   end

   // ------------------------------------------------------------------
   // Datapath and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         r_rptr       <= '0;
         r_wptr_q     <= '0;
         r_m_valid    <= 1'b0;
         r_m_data     <= '0;
         r_b_ena      <= 1'b0;
         r_b_wr       <= 1'b0;
         r_b_addr     <= '0;
         r_b_din      <= '0;
         r_ring_empty <= 1'b1;
      end else begin
         r_rptr       <= w_rptr_nxt;
         r_wptr_q     <= w_wptr_nxt;
         r_b_ena      <= w_b_ena;
         r_b_wr       <= w_b_wr;
         r_b_addr     <= w_b_addr;
         r_b_din      <= w_b_din;
         r_ring_empty <= (w_wptr_nxt == w_rptr_nxt);
         if (r_state == ST_CAP_DATA) begin
            r_m_data  <= b_dout;
            r_m_valid <= 1'b1;
         end else if (w_handshake) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   assign b_ena      = r_b_ena;
   assign b_wr       = r_b_wr;
   assign b_addr     = r_b_addr;
   assign b_din      = r_b_din;
   assign m_valid    = r_m_valid;
   assign m_data     = r_m_data;
   assign ring_empty = r_ring_empty;

endmodule : gpmc_mailbox_reader
`default_nettype wire

// File: tb/tb_gpmc_mailbox_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpmc_mailbox_reader
//  Purpose  : Bench for gpmc_mailbox_reader. A BRAM model with a host port
//             holds the ring; the host side posts words and expected results
//             go into scoreboard queues that a negedge monitor drains.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gpmc_mailbox_reader;
   import gpmc_mbox_pkg::*;

   localparam int          RL   = 10;
   localparam int          RSZ  = 1 << RL;
   localparam int          POLL = 16;
   localparam logic [10:0] WA   = c_WPTR_ADDR_DEFAULT;
   localparam logic [10:0] RA   = c_RPTR_ADDR_DEFAULT;

   logic        SYS_CLK   = 1'b0;
   logic        SYS_RST_N = 1'b0;
   logic        enable    = 1'b0;
   logic        m_ready   = 1'b0;
   logic        b_ena, b_wr, m_valid, ring_empty;
   logic [10:0] b_addr;
   logic [15:0] b_din, b_dout, m_data;

   always #5 SYS_CLK = ~SYS_CLK;

   gpmc_mailbox_reader #(
      .RING_LOG2   (RL),
      .WPTR_ADDR   (WA),
      .RPTR_ADDR   (RA),
      .POLL_CYCLES (POLL)
   ) dut (
      .SYS_CLK    (SYS_CLK),
      .SYS_RST_N  (SYS_RST_N),
      .enable     (enable),
      .b_ena      (b_ena),
      .b_wr       (b_wr),
      .b_addr     (b_addr),
      .b_din      (b_din),
      .b_dout     (b_dout),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .ring_empty (ring_empty)
   );

   // Dual-port BRAM: port A = host, port B = DUT (read latency 1).
   logic [15:0] mem [0:2047];
   logic        ha_we   = 1'b0;
   logic [10:0] ha_addr = '0;
   logic [15:0] ha_data = '0;

   always @(posedge SYS_CLK) begin
      if (ha_we) mem[ha_addr] <= ha_data;
      if (b_ena) begin
         if (b_wr) mem[b_addr] <= b_din;
         else      b_dout      <= mem[b_addr];
      end
   end

   // Reference state and scoreboards
   logic [15:0] ring_shadow [0:RSZ-1];
   logic [15:0] exp_data [$];
   int          exp_rptr [$];
   int          hs_cyc   [$];
   int          wrd_cyc  [$];
   int          host_w = 0;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          hs_cnt = 0;
   int          bena_cnt = 0;
   int          last_rptr_wr = -1;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = '0;

   always @(posedge SYS_CLK) cyc <= cyc + 1;

   // Monitor
   always @(negedge SYS_CLK) begin
      if (!SYS_RST_N) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!m_valid || m_data !== prev_data) begin
               errors++;
               $display("FAIL hold valid=%b data=%h required valid=1 data=%h", m_valid, m_data, prev_data);
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         if (m_valid && m_ready) begin
            hs_cnt++;
            hs_cyc.push_back(cyc);
            checks++;
            if (exp_data.size() == 0) begin
               errors++;
               $display("FAIL data_unexpected got %h required none", m_data);
            end else begin
               logic [15:0] e;
               e = exp_data.pop_front();
               if (m_data !== e) begin
                  errors++;
                  $display("FAIL data got %h required %h", m_data, e);
               end
            end
         end
         if (b_ena) begin
            bena_cnt++;
            if (b_wr) begin
               checks++;
               last_rptr_wr = int'(b_din);
               if (b_addr !== RA) begin
                  errors++;
                  $display("FAIL write_addr got %h required %h", b_addr, RA);
               end else if (exp_rptr.size() == 0) begin
                  errors++;
                  $display("FAIL rptr_unexpected got %0d required none", b_din);
               end else begin
                  int e;
                  e = exp_rptr.pop_front();
                  if (int'(b_din) != e) begin
                     errors++;
                     $display("FAIL rptr_write got %0d required %0d", b_din, e);
                  end
               end
            end else if (b_addr == WA) begin
               wrd_cyc.push_back(cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s got %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge SYS_CLK);
      #1;
   endtask

   task automatic host_wr(input logic [10:0] a, input logic [15:0] d);
      ha_we = 1'b1; ha_addr = a; ha_data = d;
      tick();
      ha_we = 1'b0;
   endtask

   // Host posts n words then publishes the new write pointer (with junk
   // in the unused upper bits).
   task automatic post(input int n, input bit fixed, input logic [15:0] base);
      logic [15:0] d;
      logic [15:0] wv;
      for (int i = 0; i < n; i++) begin
         d = fixed ? base + 16'(i) : 16'($urandom);
         host_wr(11'(host_w), d);
         ring_shadow[host_w] = d;
         exp_data.push_back(d);
         exp_rptr.push_back((host_w + 1) % RSZ);
         host_w = (host_w + 1) % RSZ;
      end
      wv = {6'($urandom), 10'(host_w)};
      host_wr(WA, wv);
   endtask

   task automatic drain(input int budget, input bit rnd);
      int n = 0;
      while ((exp_data.size() != 0 || exp_rptr.size() != 0) && n < budget) begin
         if (rnd) m_ready = ($urandom_range(0, 3) != 0);
         tick();
         n++;
      end
      m_ready = 1'b1;
      chk("drain_timeout", exp_data.size() + exp_rptr.size(), 0);
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!m_valid && n < budget) begin
         tick();
         n++;
      end
      chk("wait_valid", m_valid, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n, h0, b0, iter;
      repeat (2) tick();
      host_wr(WA, 16'h0000);
      host_wr(RA, 16'h5555);

      // Reset state
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_b_ena", b_ena, 0);
      chk("rst_b_wr", b_wr, 0);
      chk("rst_b_addr", b_addr, 0);
      chk("rst_b_din", b_din, 0);
      chk("rst_ring_empty", ring_empty, 1);

      // Empty ring: INIT write of 0, then evenly spaced polls
      exp_rptr.push_back(0);
      wrd_cyc.delete();
      enable = 1'b1;
      SYS_RST_N = 1'b1;
      n = 0;
      while (wrd_cyc.size() < 3 && n < 200) begin tick(); n++; end
      chk("poll_count", wrd_cyc.size(), 3);
      if (wrd_cyc.size() >= 3) begin
         chk("poll_gap1", wrd_cyc[1] - wrd_cyc[0], POLL + 2);
         chk("poll_gap2", wrd_cyc[2] - wrd_cyc[1], POLL + 2);
      end
      chk("init_write_seen", exp_rptr.size(), 0);

      // Three words back to back
      m_ready = 1'b1;
      hs_cyc.delete();
      post(3, 1'b1, 16'hA001);
      drain(300, 1'b0);
      chk("three_count", hs_cyc.size(), 3);
      if (hs_cyc.size() == 3) begin
         chk("word_gap1", hs_cyc[1] - hs_cyc[0], 4);
         chk("word_gap2", hs_cyc[2] - hs_cyc[1], 4);
      end
      chk("empty_after_three", ring_empty, 1);

      // Backpressure
      m_ready = 1'b0;
      post(1, 1'b1, 16'hBEEF);
      wait_valid(100);
      b0 = bena_cnt;
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", m_valid, 1);
         chk("bp_data", m_data, 16'hBEEF);
         tick();
      end
      chk("bp_no_bram", bena_cnt - b0, 0);
      m_ready = 1'b1;
      drain(50, 1'b0);

      // Reset pulse while a word is on offer
      m_ready = 1'b0;
      post(3, 1'b0, 16'h0);
      wait_valid(100);
      SYS_RST_N = 1'b0;
      #1;
      chk("rst_valid_drop", m_valid, 0);
      exp_data.delete();
      exp_rptr.delete();
      exp_rptr.push_back(0);
      for (int s = 0; s < host_w; s++) begin
         exp_data.push_back(ring_shadow[s]);
         exp_rptr.push_back(s + 1);
      end
      tick();
      SYS_RST_N = 1'b1;
      m_ready = 1'b1;
      drain(500, 1'b0);

      // Enable dropped in OUT with 5 words pending
      m_ready = 1'b0;
      post(5, 1'b0, 16'h0);
      wait_valid(100);
      enable = 1'b0;
      m_ready = 1'b1;
      h0 = hs_cnt;
      b0 = bena_cnt;
      repeat (40) tick();
      chk("park_one_word", hs_cnt - h0, 1);
      chk("park_one_access", bena_cnt - b0, 1);
      chk("park_left_data", exp_data.size(), 4);
      chk("park_left_rptr", exp_rptr.size(), 4);
      chk("park_valid", m_valid, 0);
      enable = 1'b1;
      drain(400, 1'b0);

      // Random traffic until the read pointer sits at RSZ-2
      iter = 0;
      while (host_w != RSZ - 2 && iter < 600) begin
         n = $urandom_range(1, 8);
         if (n > RSZ - 2 - host_w) n = RSZ - 2 - host_w;
         post(n, 1'b0, 16'h0);
         repeat ($urandom_range(0, 6)) begin
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
         end
         if (iter % 8 == 7) drain(2000, 1'b1);
         iter++;
      end
      drain(3000, 1'b1);
      chk("bulk_reach", host_w, RSZ - 2);

      // Wrap across the end of the ring
      m_ready = 1'b1;
      post(4, 1'b0, 16'h0);
      drain(400, 1'b0);
      chk("wrap_last_rptr", last_rptr_wr, 2);
      chk("wrap_empty", ring_empty, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_gpmc_mailbox_reader
`default_nettype wire
